note_scheduler: RTL and testbench

- Chart-driven sequencer that replaces the free-running note generator.
- Walks a chart ROM of {note type, frame delay} entries and issues do/ka spawn requests aligned to the one-pulse frame tick.
- Tracks outstanding notes per lane against the 8-slot note ring, and drops spawns that would overflow a full lane.
- Sits between the chart block memory and the do/ka ring-control logic; its request bus is wired exactly where the old {ka_request, do_request} pair was.

---
 rtl/note_scheduler_if.sv | 21 ++
 rtl/note_scheduler.sv | 140 ++++++++++++++
 tb/tb_note_scheduler.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/note_scheduler_if.sv
// Chart ROM bus and do/ka ring-control bus of the note scheduler.
// master = scheduler side, slave = ROM / ring-control side.
interface note_scheduler_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] chart_addr;
  logic [15:0]       chart_data;
  logic [1:0]        request;
  logic              do_retire;
  logic              ka_retire;

  modport master (
    output chart_addr, request,
    input  chart_data, do_retire, ka_retire
  );

  modport slave (
    input  chart_addr, request,
    output chart_data, do_retire, ka_retire
  );
endinterface

// File: rtl/note_scheduler.sv
// Chart-driven do/ka spawn sequencer with per-lane occupancy tracking.
// Define NOTE_SCHED_LOOP_EN to replay the chart forever instead of stopping in DONE.
module note_scheduler #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 8,
  parameter int DLY_W  = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vsync,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   pause,
  note_scheduler_if.master       bus,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             do_occ,
  output logic [3:0]             ka_occ,
  output logic [7:0]             drop_cnt
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [3:0]        FULL_OCC = 4'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        typ_q, typ_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              issue, chart_end, loop_evt, start_ok;
  logic [1:0]        full, drops;
  logic [8:0]        drop_sum;

  assign full  = {ka_occ == FULL_OCC, do_occ == FULL_OCC};
  assign drops = issue ? (typ_q & full) : 2'b00;
  assign bus.request = issue ? (typ_q & ~full) : 2'b00;
  assign bus.chart_addr = addr_q;
  assign start_ok = start && !stop && (state_q == IDLE || state_q == DONE);
  assign drop_sum = {1'b0, drop_cnt} + 9'(drops[0]) + 9'(drops[1]);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    typ_d     = typ_q;
    dly_d     = dly_q;
    issue     = 1'b0;
    chart_end = 1'b0;
    loop_evt  = 1'b0;
    unique case (state_q)
      IDLE, DONE: if (start) begin
        addr_d  = '0;
        state_d = FETCH;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        typ_d = bus.chart_data[15:14];
        if (bus.chart_data[15:14] == 2'b00) begin
          chart_end = 1'b1;
        end else begin
          dly_d   = bus.chart_data[DLY_W-1:0];
          state_d = WAIT;
        end
      end
      WAIT: if (vsync && !pause) begin
        if (dly_q == '0) begin
          issue = 1'b1;
          if (addr_q == ADDR_MAX) begin
            chart_end = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = FETCH;
          end
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (chart_end) begin
`ifdef NOTE_SCHED_LOOP_EN
      addr_d   = '0;
      state_d  = FETCH;
      loop_evt = 1'b1;
`else
      state_d  = DONE;
`endif
    end

    // Abort wins over everything, including an issue in the same vsync cycle.
    if (stop) begin
      state_d  = IDLE;
      issue    = 1'b0;
      loop_evt = 1'b0;
    end
  end

  // Issue and retire in the same cycle cancel; retire on an empty lane is ignored.
  function automatic logic [3:0] occ_next(input logic [3:0] occ, input logic inc,
                                          input logic dec);
    if (inc && !dec)                    return occ + 4'd1;
    else if (dec && !inc && occ != '0)  return occ - 4'd1;
    else                                return occ;
  endfunction

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset covers every register here; there is no memory array to leave unreset.
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      typ_q    <= '0;
      dly_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      do_occ   <= '0;
      ka_occ   <= '0;
      drop_cnt <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      typ_q    <= typ_d;
      dly_q    <= dly_d;
      busy     <= (state_d != IDLE) && (state_d != DONE);
`ifdef NOTE_SCHED_LOOP_EN
      done     <= loop_evt;
`else
      done     <= (state_d == DONE) && (state_q != DONE);
`endif
      do_occ   <= occ_next(do_occ, bus.request[0], bus.do_retire);
      ka_occ   <= occ_next(ka_occ, bus.request[1], bus.ka_retire);
      if (start_ok)               drop_cnt <= '0;
      else if (drop_sum > 9'd255) drop_cnt <= 8'hFF;
      else                        drop_cnt <= drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Directed self-checking bench for note_scheduler with a registered chart ROM model.
module tb_note_scheduler;
  localparam int ADDR_W = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vsync = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic       busy, done;
  logic [3:0] do_occ, ka_occ;
  logic [7:0] drop_cnt;
  logic [1:0] r, paused_req;
  logic [1:0] req [1:4];
  logic       seen;
  int         n_checks = 0;
  int         n_fail   = 0;

  note_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  note_scheduler #(.ADDR_W(ADDR_W), .DEPTH(8), .DLY_W(14)) dut (
    .clk      (clk),
    .rst      (rst),
    .vsync    (vsync),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .bus      (bus.master),
    .busy     (busy),
    .done     (done),
    .do_occ   (do_occ),
    .ka_occ   (ka_occ),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [1024];
  always_ff @(posedge clk) bus.chart_data <= rom[bus.chart_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vsync_pulse(input logic [1:0] ret, output logic [1:0] rq);
    vsync = 1'b1;
    bus.do_retire = ret[0];
    bus.ka_retire = ret[1];
    #1 rq = bus.request;
    @(posedge clk);
    #1;
    vsync = 1'b0;
    bus.do_retire = 1'b0;
    bus.ka_retire = 1'b0;
  endtask

  task automatic retire(input logic [1:0] lanes);
    bus.do_retire = lanes[0];
    bus.ka_retire = lanes[1];
    tick(1);
    bus.do_retire = 1'b0;
    bus.ka_retire = 1'b0;
  endtask

  task automatic go();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(output logic s);
    s = 1'b0;
    for (int i = 0; i < 20 && !s; i++) begin
      if (done) s = 1'b1;
      else tick(1);
    end
  endtask

  initial begin
    bus.do_retire = 1'b0;
    bus.ka_retire = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;

    // Reset state
    tick(2);
    check("rst_addr", 32'(bus.chart_addr), 0);
    check("rst_req", 32'(bus.request), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_occ", 32'({do_occ, ka_occ}), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    rst = 1'b1;
    tick(1);

    // Basic chart: do after 3 vsyncs, ka on the next, then end
    rom[0] = 16'h4002;
    rom[1] = 16'h8000;
    rom[2] = 16'h0000;
    go();
    check("t1_busy", 32'(busy), 1);
    for (int v = 1; v <= 4; v++) begin
      tick(99);
      vsync_pulse(2'b00, req[v]);
    end
    check("t1_req_v1", 32'(req[1]), 0);
    check("t1_req_v2", 32'(req[2]), 0);
    check("t1_req_v3", 32'(req[3]), 1);
    check("t1_req_v4", 32'(req[4]), 2);
    wait_done(seen);
    check("t1_done", 32'(seen), 1);
`ifdef NOTE_SCHED_LOOP_EN
    check("t1_loop_addr", 32'(bus.chart_addr), 0);
    tick(1);
    check("t1_busy_after", 32'(busy), 1);
    check("t1_do_occ", 32'(do_occ), 1);
    check("t1_ka_occ", 32'(ka_occ), 1);
    for (int v = 1; v <= 4; v++) begin
      tick(99);
      vsync_pulse(2'b00, r);
    end
    wait_done(seen);
    check("t1_done_loop2", 32'(seen), 1);
`else
    tick(1);
    check("t1_busy_after", 32'(busy), 0);
    check("t1_do_occ", 32'(do_occ), 1);
    check("t1_ka_occ", 32'(ka_occ), 1);
`endif

    // Nine do entries, no retire: lane saturates and the ninth spawn is dropped
    repeat (8) retire(2'b11);
    check("t2_occ_clear", 32'({do_occ, ka_occ}), 0);
    for (int i = 0; i < 9; i++) rom[i] = 16'h4000;
    rom[9] = 16'h0000;
    go();
    for (int k = 0; k < 9; k++) begin
      tick(5);
      vsync_pulse(2'b00, r);
      if (k == 7) check("t2_req8", 32'(r), 1);
      if (k == 8) check("t2_req9", 32'(r), 0);
    end
    check("t2_do_occ", 32'(do_occ), 8);
    check("t2_drop", 32'(drop_cnt), 1);

    // Issue and retire in the same cycle at occ=5; retire on empty lane
    repeat (3) retire(2'b01);
    check("t3_occ5", 32'(do_occ), 5);
    rom[0] = 16'h4000;
    rom[1] = 16'h0000;
    go();
    check("t3_drop_clr", 32'(drop_cnt), 0);
    tick(5);
    vsync_pulse(2'b01, r);
    check("t3_req", 32'(r), 1);
    check("t3_occ_same", 32'(do_occ), 5);
    repeat (5) retire(2'b01);
    check("t3_occ0", 32'(do_occ), 0);
    retire(2'b01);
    check("t3_underflow", 32'(do_occ), 0);

    // Pause freezes WAIT; delay 1 issues on the 2nd unpaused vsync
    rom[0] = 16'h4001;
    rom[1] = 16'h0000;
    go();
    tick(5);
    pause = 1'b1;
    paused_req = 2'b00;
    repeat (5) begin
      tick(3);
      vsync_pulse(2'b00, r);
      paused_req |= r;
    end
    check("t4_paused_req", 32'(paused_req), 0);
    check("t4_busy", 32'(busy), 1);
    pause = 1'b0;
    tick(3);
    vsync_pulse(2'b00, r);
    check("t4_unpaused1", 32'(r), 0);
    tick(3);
    vsync_pulse(2'b00, r);
    check("t4_unpaused2", 32'(r), 1);
    check("t4_do_occ", 32'(do_occ), 1);

    // Stop mid-WAIT together with a would-be issue
    retire(2'b01);
    for (int i = 0; i < 4; i++) rom[i] = 16'h4000;
    rom[4] = 16'h0000;
    go();
    repeat (3) begin
      tick(5);
      vsync_pulse(2'b00, r);
    end
    check("t5_occ3", 32'(do_occ), 3);
    tick(5);
    stop = 1'b1;
    vsync = 1'b1;
    #1 r = bus.request;
    check("t5_stop_req", 32'(r), 0);
    @(posedge clk);
    #1;
    stop = 1'b0;
    vsync = 1'b0;
    check("t5_busy", 32'(busy), 0);
    check("t5_occ_kept", 32'(do_occ), 3);
    tick(2);
    vsync_pulse(2'b00, r);
    check("t5_idle_req", 32'(r), 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t5_restart_addr", 32'(bus.chart_addr), 0);
    tick(5);
    vsync_pulse(2'b00, r);
    check("t5_restart_req", 32'(r), 1);
    check("t5_occ4", 32'(do_occ), 4);

    // Reset mid-run
    tick(3);
    rst = 1'b0;
    tick(1);
    check("t6_addr", 32'(bus.chart_addr), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_done", 32'(done), 0);
    check("t6_occ", 32'({do_occ, ka_occ}), 0);
    check("t6_drop", 32'(drop_cnt), 0);
    check("t6_req", 32'(bus.request), 0);
    rst = 1'b1;
    tick(2);
    check("t6_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
